// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between a requester and the alu_seq sequencer.
interface alu_seq_if;
   logic       req_valid;
   logic       req_ready;
   logic [4:0] req_op;
   logic [7:0] req_x;
   logic [7:0] req_t;
   logic       req_wb_flags;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_result;
   logic [2:0] rsp_flag;
   logic       rsp_err;

   modport slave (
      input  req_valid, req_op, req_x, req_t, req_wb_flags, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_flag, rsp_err
   );

   modport master (
      output req_valid, req_op, req_x, req_t, req_wb_flags, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_flag, rsp_err
   );
endinterface

// File: rtl/alu_seq.sv
// Single-operation sequencer around an external combinational ALU: latches a request,
// holds ALU inputs for SETTLE cycles, captures result/flags and presents a response.
module alu_seq #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_seq_if.slave   bus,
   output logic [7:0] alu_x,
   output logic [7:0] alu_t,
   output logic       alu_cy,
   output logic [4:0] alu_op,
   input  logic [7:0] alu_result,
   input  logic [2:0] alu_flag,
   output logic       flag_s,
   output logic       flag_z,
   output logic       flag_cy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [2:0] CNT_LAST = 3'(SETTLE - 1);

   state_t     state_reg, state_next;
   logic [2:0] cnt_reg;
   logic [7:0] x_reg, t_reg;
   logic [4:0] op_reg;
   logic       wb_reg;
   logic [7:0] result_reg;
   logic [2:0] rflag_reg;
   logic       err_reg;
   logic [2:0] flags_reg;
   logic       accept, capture, op_legal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: if (bus.req_valid) begin
            accept     = 1'b1;
            state_next = EXEC;
         end
         EXEC: if (cnt_reg == CNT_LAST) begin
            capture    = 1'b1;
            state_next = RESP;
         end
         RESP: if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Legal: 00000-00010, 01xxx, 10000-10100, 110xx
   always_comb begin
      op_legal = 1'b0;
      case (op_reg[4:3])
         2'b00: op_legal = (op_reg[2:0] <= 3'd2);
         2'b01: op_legal = 1'b1;
         2'b10: op_legal = (op_reg[2:0] <= 3'd4);
         2'b11: op_legal = ~op_reg[2];
         default: op_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg    <= 3'd0;
         x_reg      <= 8'h00;
         t_reg      <= 8'h00;
         op_reg     <= 5'b00000;
         wb_reg     <= 1'b0;
         result_reg <= 8'h00;
         rflag_reg  <= 3'b000;
         err_reg    <= 1'b0;
         flags_reg  <= 3'b000;
      end else begin
         if (accept) begin
            x_reg   <= bus.req_x;
            t_reg   <= bus.req_t;
            op_reg  <= bus.req_op;
            wb_reg  <= bus.req_wb_flags;
            cnt_reg <= 3'd0;
         end else if (state_reg == EXEC) begin
            cnt_reg <= cnt_reg + 3'd1;
         end
         if (capture) begin
            if (op_legal) begin
               result_reg <= alu_result;
               rflag_reg  <= alu_flag;
               err_reg    <= 1'b0;
               if (wb_reg) flags_reg <= alu_flag;
            end else begin
               result_reg <= 8'h00;
               rflag_reg  <= 3'b000;
               err_reg    <= 1'b1;
            end
         end
      end
   end

   assign bus.req_ready  = (state_reg == IDLE);
   assign bus.rsp_valid  = (state_reg == RESP);
   assign bus.rsp_result = result_reg;
   assign bus.rsp_flag   = rflag_reg;
   assign bus.rsp_err    = err_reg;

   assign alu_x   = x_reg;
   assign alu_t   = t_reg;
   assign alu_op  = op_reg;
   // Flags only move at capture, so the carry is constant for the whole EXEC phase.
   assign alu_cy  = flags_reg[0];
   assign flag_s  = flags_reg[2];
   assign flag_z  = flags_reg[1];
   assign flag_cy = flags_reg[0];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a SETTLE=1 instance for the functional vectors and a
// SETTLE=3 instance for latency and mid-operation reset, each with a small ALU model.
module tb_alu_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1_n, rst3_n;
   alu_seq_if b1 ();
   alu_seq_if b3 ();

   logic [7:0] a1_x, a1_t, a1_res, a3_x, a3_t, a3_res;
   logic [4:0] a1_op, a3_op;
   logic       a1_cy, a3_cy;
   logic [2:0] a1_flag, a3_flag;
   logic       a1_fs, a1_fz, a1_fc, a3_fs, a3_fz, a3_fc;

   int n_vec = 0;
   int n_err = 0;

   // Stand-in ALU: ADD, ADC, SUB (carry = no borrow); other codes pass X through.
   function automatic logic [10:0] alu_model(input logic [4:0] op, input logic [7:0] x,
                                             input logic [7:0] t, input logic cy);
      logic [8:0] s;
      case (op)
         5'b01000: s = {1'b0, x} + {1'b0, t};
         5'b01010: s = {1'b0, x} + {1'b0, t} + {8'd0, cy};
         5'b01011: s = {1'b0, x} + {1'b0, ~t} + 9'd1;
         default:  s = {1'b0, x};
      endcase
      return {s[7], (s[7:0] == 8'h00), s[8], s[7:0]};
   endfunction

   assign {a1_flag, a1_res} = alu_model(a1_op, a1_x, a1_t, a1_cy);
   assign {a3_flag, a3_res} = alu_model(a3_op, a3_x, a3_t, a3_cy);

   alu_seq #(.SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .bus(b1.slave),
      .alu_x(a1_x), .alu_t(a1_t), .alu_cy(a1_cy), .alu_op(a1_op),
      .alu_result(a1_res), .alu_flag(a1_flag),
      .flag_s(a1_fs), .flag_z(a1_fz), .flag_cy(a1_fc)
   );

   alu_seq #(.SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .bus(b3.slave),
      .alu_x(a3_x), .alu_t(a3_t), .alu_cy(a3_cy), .alu_op(a3_op),
      .alu_result(a3_res), .alu_flag(a3_flag),
      .flag_s(a3_fs), .flag_z(a3_fz), .flag_cy(a3_fc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One full SETTLE=1 transaction on dut1 with response handshake.
   task automatic do_op(input string tag, input logic [4:0] op, input logic [7:0] x,
                        input logic [7:0] t, input logic wb, input logic exp_cy,
                        input logic [7:0] exp_res, input logic [2:0] exp_flag,
                        input logic exp_err, input logic [2:0] exp_flags);
      int lat;
      @(negedge clk);
      check({tag, ".req_ready"}, 32'(b1.req_ready), 32'd1);
      b1.req_valid = 1'b1; b1.req_op = op; b1.req_x = x; b1.req_t = t; b1.req_wb_flags = wb;
      @(posedge clk);
      @(negedge clk);
      b1.req_valid = 1'b0;
      check({tag, ".busy"}, 32'(b1.req_ready), 32'd0);
      check({tag, ".alu_op"}, 32'(a1_op), 32'(op));
      check({tag, ".alu_cy"}, 32'(a1_cy), 32'(exp_cy));
      lat = 0;
      while (!b1.rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'd1);
      check({tag, ".result"}, 32'(b1.rsp_result), 32'(exp_res));
      check({tag, ".rsp_flag"}, 32'(b1.rsp_flag), 32'(exp_flag));
      check({tag, ".rsp_err"}, 32'(b1.rsp_err), 32'(exp_err));
      check({tag, ".flags"}, 32'({a1_fs, a1_fz, a1_fc}), 32'(exp_flags));
      $display("txn %s op=%b x=%h t=%h wb=%b -> res=%h flag=%b err=%b flags=%b", tag, op, x, t,
               wb, b1.rsp_result, b1.rsp_flag, b1.rsp_err, {a1_fs, a1_fz, a1_fc});
      b1.rsp_ready = 1'b1;
      @(negedge clk);
      b1.rsp_ready = 1'b0;
      check({tag, ".rsp_done"}, 32'(b1.rsp_valid), 32'd0);
   endtask

   initial begin
      int lat;
      rst1_n = 1'b0; rst3_n = 1'b0;
      b1.req_valid = 1'b0; b1.req_op = '0; b1.req_x = '0; b1.req_t = '0;
      b1.req_wb_flags = 1'b0; b1.rsp_ready = 1'b0;
      b3.req_valid = 1'b0; b3.req_op = '0; b3.req_x = '0; b3.req_t = '0;
      b3.req_wb_flags = 1'b0; b3.rsp_ready = 1'b0;
      #12;
      check("rst.rsp_valid", 32'(b1.rsp_valid), 32'd0);
      check("rst.alu_x", 32'(a1_x), 32'd0);
      check("rst.alu_op", 32'(a1_op), 32'd0);
      check("rst.result", 32'(b1.rsp_result), 32'd0);
      check("rst.flags", 32'({a1_fs, a1_fz, a1_fc}), 32'd0);
      @(negedge clk);
      rst1_n = 1'b1; rst3_n = 1'b1;
      check("rst.req_ready", 32'(b1.req_ready), 32'd1);

      do_op("add",    5'b01000, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 3'b011, 1'b0, 3'b011);
      do_op("adc",    5'b01010, 8'h01, 8'h01, 1'b1, 1'b1, 8'h03, 3'b000, 1'b0, 3'b000);
      do_op("sub",    5'b01011, 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 3'b100, 1'b0, 3'b000);
      do_op("add2",   5'b01000, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 3'b011, 1'b0, 3'b011);
      do_op("ill3",   5'b00011, 8'h80, 8'h00, 1'b1, 1'b1, 8'h00, 3'b000, 1'b1, 3'b011);
      do_op("op14",   5'b10100, 8'h80, 8'h00, 1'b0, 1'b1, 8'h80, 3'b100, 1'b0, 3'b011);
      do_op("ill15",  5'b10101, 8'h80, 8'h00, 1'b1, 1'b1, 8'h00, 3'b000, 1'b1, 3'b011);
      do_op("op1b",   5'b11011, 8'h40, 8'h00, 1'b0, 1'b1, 8'h40, 3'b000, 1'b0, 3'b011);
      do_op("ill1c",  5'b11100, 8'h40, 8'h00, 1'b1, 1'b1, 8'h00, 3'b000, 1'b1, 3'b011);
      do_op("op02",   5'b00010, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 3'b010, 1'b0, 3'b010);

      // Response back-pressure with a second request waiting.
      @(negedge clk);
      b1.req_valid = 1'b1; b1.req_op = 5'b01000; b1.req_x = 8'h01; b1.req_t = 8'h02;
      b1.req_wb_flags = 1'b0;
      @(posedge clk);
      @(negedge clk);
      b1.req_x = 8'h10; b1.req_t = 8'h20;
      @(negedge clk);
      check("stall.rsp_valid", 32'(b1.rsp_valid), 32'd1);
      check("stall.result", 32'(b1.rsp_result), 32'h03);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall.hold_valid", 32'(b1.rsp_valid), 32'd1);
         check("stall.hold_result", 32'(b1.rsp_result), 32'h03);
         check("stall.hold_ready", 32'(b1.req_ready), 32'd0);
         check("stall.hold_x", 32'(a1_x), 32'h01);
      end
      $display("txn stall op=01000 x=01 t=02 held 5 cycles res=%h", b1.rsp_result);
      b1.rsp_ready = 1'b1;
      @(negedge clk);
      b1.rsp_ready = 1'b0;
      check("stall.idle_ready", 32'(b1.req_ready), 32'd1);
      check("stall.idle_valid", 32'(b1.rsp_valid), 32'd0);
      @(negedge clk);
      b1.req_valid = 1'b0;
      check("stall.accept2", 32'(b1.req_ready), 32'd0);
      check("stall.alu_x2", 32'(a1_x), 32'h10);
      @(negedge clk);
      check("stall.result2", 32'(b1.rsp_result), 32'h30);
      $display("txn second op=01000 x=10 t=20 -> res=%h", b1.rsp_result);
      b1.rsp_ready = 1'b1;
      @(negedge clk);
      b1.rsp_ready = 1'b0;

      // SETTLE=3: latency and flag write-back.
      b3.req_valid = 1'b1; b3.req_op = 5'b01000; b3.req_x = 8'hFF; b3.req_t = 8'h01;
      b3.req_wb_flags = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b3.req_valid = 1'b0;
      lat = 0;
      while (!b3.rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("s3.latency", 32'(lat), 32'd3);
      check("s3.flags", 32'({a3_fs, a3_fz, a3_fc}), 32'b011);
      $display("txn s3 op=01000 x=ff t=01 -> res=%h lat=%0d", b3.rsp_result, lat);
      b3.rsp_ready = 1'b1;
      @(negedge clk);
      b3.rsp_ready = 1'b0;

      // SETTLE=3: reset asserted during the second EXEC cycle.
      b3.req_valid = 1'b1; b3.req_op = 5'b01000; b3.req_x = 8'h05; b3.req_t = 8'h05;
      @(posedge clk);
      @(negedge clk);
      b3.req_valid = 1'b0;
      @(posedge clk);
      #2 rst3_n = 1'b0;
      #1;
      check("abort.rsp_valid", 32'(b3.rsp_valid), 32'd0);
      check("abort.alu_x", 32'(a3_x), 32'd0);
      check("abort.alu_t", 32'(a3_t), 32'd0);
      check("abort.alu_op", 32'(a3_op), 32'd0);
      check("abort.flags", 32'({a3_fs, a3_fz, a3_fc}), 32'd0);
      check("abort.result", 32'(b3.rsp_result), 32'd0);
      check("abort.err", 32'(b3.rsp_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst3_n = 1'b1;
      check("abort.req_ready", 32'(b3.req_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort.no_rsp", 32'(b3.rsp_valid), 32'd0);
      end
      $display("txn abort op=01000 x=05 t=05 reset in EXEC flags=%b", {a3_fs, a3_fz, a3_fc});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter SETTLE, default 1, meaning: number of EXEC cycles ALU inputs are held stable before capture; legal range 1..4.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low (ports clk and rst_n).
REQ-003 clk  in  1  system clock, all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_op  in  5  ALU operation code.
REQ-008 req_x  in  8  X operand.
REQ-009 req_t  in  8  T operand.
REQ-010 req_wb_flags  in  1  1 = write ALU flags into flag register.
REQ-011 alu_x  out  8  registered X to ALU.
REQ-012 alu_t  out  8  registered T to ALU.
REQ-013 alu_cy  out  1  carry to ALU, equal to flag_cy.
REQ-014 alu_op  out  5  registered op to ALU.
REQ-015 alu_result  in  8  ALU result.
REQ-016 alu_flag  in  3  ALU flags {S,Z,Cy}.
REQ-017 rsp_valid  out  1  response present.
REQ-018 rsp_ready  in  1  consumer accepts response.
REQ-019 rsp_result  out  8  captured result.
REQ-020 rsp_flag  out  3  captured {S,Z,Cy}.
REQ-021 rsp_err  out  1  1 = request carried an illegal op.
REQ-022 flag_s, flag_z, flag_cy  out  1 each  architectural flag register.

Function
REQ-023 FSM states IDLE, EXEC, RESP; req_ready SHALL be 1 only in IDLE, rsp_valid SHALL be 1 only in RESP.
REQ-024 IDLE: on edge with req_valid=1, SHALL latch req_op/req_x/req_t/req_wb_flags into alu_op/alu_x/alu_t/wb register, clear settle counter, go EXEC.
REQ-025 EXEC: SHALL hold alu_x/alu_t/alu_op/alu_cy stable; counter increments each cycle; on the SETTLE-th EXEC edge SHALL capture and go RESP.
REQ-026 rsp_valid SHALL rise exactly SETTLE cycles after the accepting edge; minimum cycle per operation is SETTLE+2.
REQ-027 Legal ops: 00000, 00001, 00010, 01000-01111, 10000-10100, 11000-11011; any other code is illegal.
REQ-028 Capture, legal op: rsp_result=alu_result, rsp_flag=alu_flag, rsp_err=0; if wb=1, {flag_s,flag_z,flag_cy}=alu_flag, else flags unchanged.
REQ-029 Capture, illegal op: rsp_result=8'h00, rsp_flag=3'b000, rsp_err=1, flags unchanged regardless of wb.
REQ-030 RESP: rsp_result/rsp_flag/rsp_err SHALL be stable while rsp_valid=1 and rsp_ready=0; on edge with rsp_ready=1 go IDLE.
REQ-031 req_valid in EXEC/RESP SHALL be ignored (no queueing); no bypass from RESP to EXEC.
REQ-032 alu_cy SHALL reflect flag_cy; since flags change only at capture, the carry seen by an op is the flag value at its accept.
REQ-033 alu_x/alu_t/alu_op SHALL retain last values in IDLE and RESP.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE, counter 0, alu_x/alu_t=8'h00, alu_op=5'b00000, rsp_result=8'h00, rsp_flag=3'b000, rsp_err=0, flags 0, rsp_valid=0; req_ready=1 after release.
REQ-035 Reset during EXEC or RESP SHALL abort the operation with no flag update and no response.

Verification (bench instantiates alu_seq with the team ALU connected)
REQ-036 SETTLE=1, op 01000, x=FF, t=01, wb=1 -> rsp_valid 1 cycle after accept, rsp_result 00, rsp_flag 3'b011, flag_cy=1, flag_z=1.
REQ-037 Follow-up op 01010, x=01, t=01, wb=1 -> alu_cy=1, rsp_result 03, rsp_flag 3'b000, flags cleared.
REQ-038 op 01011, x=00, t=01, wb=0 -> rsp_result FF, rsp_flag 3'b100, flag register unchanged.
REQ-039 rsp_ready held 0 for 5 cycles with req_valid=1 -> rsp_valid and rsp_result stable, req_ready=0, second request accepted only in the cycle after the rsp handshake.
REQ-040 Illegal op 00011 with wb=1 -> rsp_err 1, rsp_result 00, rsp_flag 000, flags unchanged.
REQ-041 SETTLE=3, rst_n low on 2nd EXEC cycle -> outputs at reset values at once, no rsp_valid, flags 000, req_ready 1 after release.
